exec_ctrl: RTL

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/siaa_pkg.sv | 52 +++++
 rtl/exec_decode.sv | 64 ++++++
 rtl/exec_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/siaa_pkg.sv
// siaa_pkg: shared definitions for the execution controller and the ALU.
//   - width parameters (instruction 9, pc 10, data 8)
//   - controller state enum
//   - R-type (4-bit) and I-type (3-bit) opcode constants
//   - signExtData(): sign-extend a data byte to pc width
package siaa_pkg;

    localparam int INSTR_W = 9;
    localparam int PC_W    = 10;
    localparam int DATA_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } execState_t;

    // R-type opcodes, IR[7:4] when IR[8] = 0
    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] AND = 4'b0010;
    localparam logic [3:0] OR  = 4'b0011;
    localparam logic [3:0] XOR = 4'b0100;
    localparam logic [3:0] NOT = 4'b0101;
    localparam logic [3:0] SHL = 4'b0110;
    localparam logic [3:0] SHR = 4'b0111;
    localparam logic [3:0] LW  = 4'b1000;
    localparam logic [3:0] SW  = 4'b1001;
    localparam logic [3:0] MOV = 4'b1010;
    localparam logic [3:0] CMP = 4'b1011;
    localparam logic [3:0] BR  = 4'b1100;
    localparam logic [3:0] J   = 4'b1101;
    localparam logic [3:0] SET = 4'b1110;
    localparam logic [3:0] LA  = 4'b1111;

    // I-type opcodes, IR[7:5] when IR[8] = 1
    localparam logic [2:0] ADDI = 3'b000;
    localparam logic [2:0] SUBI = 3'b001;
    localparam logic [2:0] ANDI = 3'b010;
    localparam logic [2:0] ORI  = 3'b011;
    localparam logic [2:0] SHLI = 3'b100;
    localparam logic [2:0] SETI = 3'b101;
    localparam logic [2:0] NOP  = 3'b110;
    localparam logic [2:0] HALT = 3'b111;

    function automatic logic [PC_W-1:0] signExtData(input logic [DATA_W-1:0] d);
        return {{(PC_W-DATA_W){d[DATA_W-1]}}, d};
    endfunction

endpackage

// File: rtl/exec_decode.sv
// exec_decode: combinational field extraction and op classification of IR.
// Ports:
//   ir         in   9  latched instruction register
//   typeCode   out  1  IR[8], 1 = I-type
//   rOp        out  4  R-type opcode (0 for I-type)
//   iOp        out  3  I-type opcode (0 for R-type)
//   imm        out  5  I-type immediate (0 for R-type)
//   regSel     out  4  R-type register select (0 for I-type)
//   isMem, isStore, isBranch, isJump, writesAcc, writesReg, isHalt, isCarryOp
//              out  1  op classification flags
module exec_decode
    import siaa_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output logic               typeCode,
    output logic [3:0]         rOp,
    output logic [2:0]         iOp,
    output logic [4:0]         imm,
    output logic [3:0]         regSel,
    output logic               isMem,
    output logic               isStore,
    output logic               isBranch,
    output logic               isJump,
    output logic               writesAcc,
    output logic               writesReg,
    output logic               isHalt,
    output logic               isCarryOp
);

    always_comb begin
        typeCode  = ir[8];
        rOp       = '0;
        iOp       = '0;
        imm       = '0;
        regSel    = '0;
        isMem     = 1'b0;
        isStore   = 1'b0;
        isBranch  = 1'b0;
        isJump    = 1'b0;
        writesAcc = 1'b0;
        writesReg = 1'b0;
        isHalt    = 1'b0;
        isCarryOp = 1'b0;
        if (!ir[8]) begin
            rOp       = ir[7:4];
            regSel    = ir[3:0];
            isMem     = (rOp == LW) || (rOp == SW);
            isStore   = (rOp == SW);
            isBranch  = (rOp == BR);
            isJump    = (rOp == J);
            writesReg = (rOp == SET);
            // LW returns its data through the accumulator; SW writes nothing
            writesAcc = ((rOp <= CMP) && (rOp != SW)) || (rOp == LA);
            isCarryOp = (rOp == ADD) || (rOp == SUB);
        end else begin
            iOp       = ir[7:5];
            imm       = ir[4:0];
            isHalt    = (iOp == HALT);
            writesAcc = (iOp <= SETI);
            isCarryOp = (iOp == ADDI) || (iOp == SUBI);
        end
    end

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: instruction sequencer -- fetch/exec/mem/writeback FSM, program
// counter and optional carry chain.
// Build option: CARRY_CHAIN_EN -- when defined, a carry register captures
// alu_sc_out in WB of ADD/SUB/ADDI/SUBI and drives sc_in; otherwise sc_in = 0.
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   start                        in   leave IDLE and fetch at current pc
//   instr[8:0]                   in   instruction memory word at pc
//   pc[9:0]                      out  program counter
//   type_code, r_op, i_op, imm, reg_sel   out  decoded IR fields
//   op_reg[7:0]                  in   regfile read data at reg_sel
//   alu_branch, alu_sc_out       in   ALU branch flag and carry out
//   sc_in                        out  carry into the ALU
//   acc_we, reg_we               out  writeback strobes
//   mem_req, mem_we, mem_ack     data memory handshake
//   done                         out  halted
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for start, pc frozen
// ST_FETCH | IR <= instr
// ST_EXEC  | decode; route to MEM, WB, or IDLE on HALT
// ST_MEM   | mem_req held until mem_ack
// ST_WB    | writeback strobes, pc update, carry capture
module exec_ctrl
    import siaa_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               type_code,
    output logic [3:0]         r_op,
    output logic [2:0]         i_op,
    output logic [4:0]         imm,
    output logic [3:0]         reg_sel,
    input  logic [DATA_W-1:0]  op_reg,
    input  logic               alu_branch,
    input  logic               alu_sc_out,
    output logic               sc_in,
    output logic               acc_we,
    output logic               reg_we,
    output logic               mem_req,
    output logic               mem_we,
    input  logic               mem_ack,
    output logic               done
);

    execState_t         state;
    execState_t         stateNext;
    logic [INSTR_W-1:0] irReg;
    logic [PC_W-1:0]    pcReg;
    logic [PC_W-1:0]    pcNext;
    logic               doneReg;

    logic isMem;
    logic isStore;
    logic isBranch;
    logic isJump;
    logic writesAcc;
    logic writesReg;
    logic isHalt;
    logic isCarryOp;

    exec_decode uDecode (
        .ir        (irReg),
        .typeCode  (type_code),
        .rOp       (r_op),
        .iOp       (i_op),
        .imm       (imm),
        .regSel    (reg_sel),
        .isMem     (isMem),
        .isStore   (isStore),
        .isBranch  (isBranch),
        .isJump    (isJump),
        .writesAcc (writesAcc),
        .writesReg (writesReg),
        .isHalt    (isHalt),
        .isCarryOp (isCarryOp)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Strobes are pure functions of state so reset clears them without a clock
    always_comb begin
        stateNext = state;
        acc_we    = 1'b0;
        reg_we    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    stateNext = ST_FETCH;
                end
            end
            ST_FETCH: begin
                stateNext = ST_EXEC;
            end
            ST_EXEC: begin
                if (isHalt) begin
                    stateNext = ST_IDLE;
                end else if (isMem) begin
                    stateNext = ST_MEM;
                end else begin
                    stateNext = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = isStore;
                if (mem_ack) begin
                    stateNext = ST_WB;
                end
            end
            ST_WB: begin
                acc_we    = writesAcc;
                reg_we    = writesReg;
                stateNext = ST_FETCH;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Natural PC_W-bit wrap gives the mod-1024 behaviour
    always_comb begin
        pcNext = pcReg + PC_W'(1);
        if (isJump) begin
            pcNext = PC_W'(op_reg);
        end else if (isBranch && alu_branch) begin
            pcNext = pcReg + signExtData(op_reg);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irReg   <= '0;
            pcReg   <= '0;
            doneReg <= 1'b0;
        end else begin
            if (state == ST_FETCH) begin
                irReg <= instr;
            end
            if (state == ST_WB) begin
                pcReg <= pcNext;
            end
            if ((state == ST_EXEC) && isHalt) begin
                doneReg <= 1'b1;
            end else if ((state == ST_IDLE) && start) begin
                doneReg <= 1'b0;
            end
        end
    end

`ifdef CARRY_CHAIN_EN
    logic carryReg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            carryReg <= 1'b0;
        end else if ((state == ST_WB) && isCarryOp) begin
            carryReg <= alu_sc_out;
        end
    end

    assign sc_in = carryReg;
`else
    // No carry chain: the carry flag and op class have no consumer
    logic unusedSc;
    assign unusedSc = alu_sc_out ^ isCarryOp;
    assign sc_in    = 1'b0;
`endif

    assign pc   = pcReg;
    assign done = doneReg;

endmodule
